// File: rtl/fp_multiply_sequencer_if.sv
// Handshake bundle for the FP multiply sequencer.
//   in_valid/in_ready/in_a/in_b          : operand-pair request channel
//   out_valid/out_ready/out_result/flags : result channel, flags = {invalid, overflow, underflow, inexact}
// master = operand producer / result consumer, slave = the sequencer.
interface fp_multiply_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_multiply_sequencer.sv
// Multi-cycle IEEE-754 single-precision multiplier (truncating, denormals flushed).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : operand/result handshake (slave side of fp_multiply_sequencer_if)
//   busy  : high whenever the sequencer is not IDLE
module fp_multiply_sequencer #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned BIAS           = 127
) (
  input  logic                          clk,
  input  logic                          reset,
  fp_multiply_sequencer_if.slave        bus,
  output logic                          busy
);

  localparam int unsigned MULT_CYCLES = 24 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned ACC_W       = 48;

  typedef enum logic [2:0] {IDLE, MULT, NORM, PACK, DONE} state_t;

  state_t state_q, state_d;

  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [23:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [7:0]       ea_q, ea_d;
  logic [7:0]       eb_q, eb_d;
  logic signed [9:0] e_q, e_d;
  logic [22:0]      mant_q, mant_d;
  logic             inexact_q, inexact_d;
  logic             special_q, special_d;
  logic [31:0]      spec_res_q, spec_res_d;
  logic [3:0]       spec_flags_q, spec_flags_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;

  // Operand classification, evaluated combinationally on the live inputs.
  logic       accept_c;
  logic [7:0] a_exp_c, b_exp_c;
  logic       a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;
  logic       special_c;
  logic       sign_c;

  always_comb begin
    accept_c = bus.in_valid & in_ready_q;
    a_exp_c  = bus.in_a[30:23];
    b_exp_c  = bus.in_b[30:23];
    sign_c   = bus.in_a[31] ^ bus.in_b[31];
    a_zero_c = (a_exp_c == 8'h00);
    b_zero_c = (b_exp_c == 8'h00);
    a_inf_c  = (a_exp_c == 8'hFF) && (bus.in_a[22:0] == 23'd0);
    b_inf_c  = (b_exp_c == 8'hFF) && (bus.in_b[22:0] == 23'd0);
    a_nan_c  = (a_exp_c == 8'hFF) && (bus.in_a[22:0] != 23'd0);
    b_nan_c  = (b_exp_c == 8'hFF) && (bus.in_b[22:0] != 23'd0);
    special_c = a_zero_c | b_zero_c | a_inf_c | b_inf_c | a_nan_c | b_nan_c;
  end

  // Sum of multiplicand copies selected by the current multiplier digit.
  logic [ACC_W-1:0] partial_c;
  always_comb begin
    partial_c = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) partial_c = partial_c + (mcand_q << i);
    end
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = special_c ? PACK : MULT;
      MULT: if (cnt_q == CNT_W'(MULT_CYCLES - 1)) state_d = NORM;
      NORM: state_d = PACK;
      PACK: state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the flops reflect the state they accompany.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    if (state_d == IDLE) begin
      in_ready_d = 1'b1;
      busy_d     = 1'b0;
    end
    if (state_d == DONE) out_valid_d = 1'b1;
  end

  // Datapath next values.
  always_comb begin
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    sign_d       = sign_q;
    ea_d         = ea_q;
    eb_d         = eb_q;
    e_d          = e_q;
    mant_d       = mant_q;
    inexact_d    = inexact_q;
    special_d    = special_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          sign_d       = sign_c;
          ea_d         = a_exp_c;
          eb_d         = b_exp_c;
          mplier_d     = {1'b1, bus.in_a[22:0]};
          mcand_d      = {24'd0, 1'b1, bus.in_b[22:0]};
          acc_d        = '0;
          cnt_d        = '0;
          special_d    = special_c;
          spec_flags_d = 4'b0000;
          if (a_nan_c | b_nan_c | (a_zero_c & b_inf_c) | (a_inf_c & b_zero_c)) begin
            spec_res_d   = 32'h7FC0_0000;
            spec_flags_d = 4'b1000;
          end else if (a_inf_c | b_inf_c) begin
            spec_res_d = {sign_c, 8'hFF, 23'd0};
          end else begin
            spec_res_d = {sign_c, 31'd0};
          end
        end
      end
      MULT: begin
        acc_d    = acc_q + partial_c;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      NORM: begin
        // Product of two [1,2) mantissas lies in [1,4): at most one shift needed.
        e_d = 10'(ea_q) + 10'(eb_q) - 10'(BIAS);
        if (acc_q[47]) begin
          mant_d    = acc_q[46:24];
          inexact_d = |acc_q[23:0];
          e_d       = e_d + 10'sd1;
        end else begin
          mant_d    = acc_q[45:23];
          inexact_d = |acc_q[22:0];
        end
      end
      PACK: begin
        if (special_q) begin
          out_result_d = spec_res_q;
          out_flags_d  = spec_flags_q;
        end else if (e_q >= 10'sd255) begin
          out_result_d = {sign_q, 8'hFF, 23'd0};
          out_flags_d  = 4'b0101;
        end else if (e_q <= 10'sd0) begin
          out_result_d = {sign_q, 31'd0};
          out_flags_d  = 4'b0011;
        end else begin
          out_result_d = {sign_q, e_q[7:0], mant_q};
          out_flags_d  = {3'b000, inexact_q};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      sign_q       <= 1'b0;
      ea_q         <= '0;
      eb_q         <= '0;
      e_q          <= '0;
      mant_q       <= '0;
      inexact_q    <= 1'b0;
      special_q    <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      sign_q       <= sign_d;
      ea_q         <= ea_d;
      eb_q         <= eb_d;
      e_q          <= e_d;
      mant_q       <= mant_d;
      inexact_q    <= inexact_d;
      special_q    <= special_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fp_multiply_sequencer.sv
// Directed bench for fp_multiply_sequencer: one instance per BITS_PER_CYCLE setting (1 and 4).
module tb_fp_multiply_sequencer;

  logic clk;
  logic reset;
  logic busy0, busy1;
  int   checks;
  int   errors;

  fp_multiply_sequencer_if if0 ();
  fp_multiply_sequencer_if if1 ();

  fp_multiply_sequencer #(.BITS_PER_CYCLE(1), .BIAS(127)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0), .busy(busy0)
  );
  fp_multiply_sequencer #(.BITS_PER_CYCLE(4), .BIAS(127)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      if0.in_valid = v; if0.in_a = a; if0.in_b = b;
    end else begin
      if1.in_valid = v; if1.in_a = a; if1.in_b = b;
    end
  endtask

  task automatic set_ordy(input int sel, input logic r);
    if (sel == 0) if0.out_ready = r;
    else          if1.out_ready = r;
  endtask

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? if0.out_valid : if1.out_valid;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel == 0) ? if0.in_ready : if1.in_ready;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic [31:0] get_res(input int sel);
    return (sel == 0) ? if0.out_result : if1.out_result;
  endfunction
  function automatic logic [3:0] get_flags(input int sel);
    return (sel == 0) ? if0.out_flags : if1.out_flags;
  endfunction

  // Accept edge ends cycle N; k counts edges after it, so out_valid first seen at cycle N+k.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [3:0] exp_f,
                        input int exp_lat, input string tag);
    int k;
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'd0, 32'd0);
    k = 1;
    chk({tag, "_busy_start"}, 32'(get_busy(sel)), 32'd1);
    while (!get_ov(sel) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "_result"}, get_res(sel), exp_r);
    chk({tag, "_flags"}, 32'(get_flags(sel)), 32'(exp_f));
    chk({tag, "_busy_done"}, 32'(get_busy(sel)), 32'd1);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    chk({tag, "_ov_drop"}, 32'(get_ov(sel)), 32'd0);
    chk({tag, "_idle_ready"}, 32'(get_ir(sel)), 32'd1);
    chk({tag, "_idle_busy"}, 32'(get_busy(sel)), 32'd0);
    chk({tag, "_retain"}, get_res(sel), exp_r);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 32'd0, 32'd0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", 32'(get_ir(s)), 32'd1);
      chk("rst_out_valid", 32'(get_ov(s)), 32'd0);
      chk("rst_result", get_res(s), 32'd0);
      chk("rst_flags", 32'(get_flags(s)), 32'd0);
      chk("rst_busy", 32'(get_busy(s)), 32'd0);
    end

    // Normal path, BITS_PER_CYCLE=1
    run_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 27, "one_x_one");
    run_op(0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 27, "p47_path");
    run_op(0, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 27, "neg2_x_3");
    run_op(0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, 27, "inexact");
    run_op(0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, 27, "overflow");
    run_op(0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, 27, "underflow");

    // Special cases
    run_op(0, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 2, "zero_x_inf");
    run_op(0, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 2, "ninf_x_2");
    run_op(0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 2, "nan_x_1");

    // Backpressure: result held while a second request waits
    drive(0, 1'b1, 32'hFF80_0000, 32'h4000_0000);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h0000_0000, 32'h3F80_0000);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(get_ov(0)), 32'd1);
      chk("bp_result", get_res(0), 32'hFF80_0000);
      chk("bp_flags", 32'(get_flags(0)), 32'd0);
      chk("bp_in_ready", 32'(get_ir(0)), 32'd0);
      @(posedge clk); #1;
    end
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    chk("bp_release_ov", 32'(get_ov(0)), 32'd0);
    chk("bp_release_ready", 32'(get_ir(0)), 32'd1);
    chk("bp_release_result", get_res(0), 32'hFF80_0000);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0);
    chk("bp_second_busy", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_ov", 32'(get_ov(0)), 32'd1);
    chk("bp_second_result", get_res(0), 32'h0000_0000);
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    chk("bp_second_done", 32'(get_ov(0)), 32'd0);

    // Leave a nonzero result, then reset mid-MULT
    run_op(0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 27, "pre_reset");
    drive(0, 1'b1, 32'h4000_0000, 32'h4000_0000);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(get_ov(0)), 32'd0);
    chk("mid_rst_result", get_res(0), 32'd0);
    chk("mid_rst_in_ready", 32'(get_ir(0)), 32'd1);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    run_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 27, "post_reset");

    // BITS_PER_CYCLE=4 instance
    run_op(1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 9, "b4_one_x_one");
    run_op(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 9, "b4_p47_path");
    run_op(1, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 9, "b4_neg2_x_3");
    run_op(1, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, 9, "b4_inexact");
    run_op(1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, 9, "b4_overflow");
    run_op(1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, 9, "b4_underflow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
